// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
//   - uart_state_e : receiver state encoding
//   - UART_SAMPLE_RATIO / UART_DATA_BITS : default parameter values
//   - majority3()  : 2-of-3 vote used for bit decisions
package uart_pkg;

    localparam int UART_SAMPLE_RATIO = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_oversampler_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to 1 so an idle-high serial line reads idle out of reset.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   i_d   in  asynchronous input
//   o_q   out synchronized output (2 clk latency)
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: oversampling UART receiver (start, DATA_BITS LSB-first, stop).
// Each bit is a 2-of-3 vote over synced samples at counter M-1, M, M+1
// (M = SAMPLE_RATIO/2); all state moves only on sample_tick.
// Optional parity bit after the data bits when UART_RX_PARITY_EN is defined.
// Ports:
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   sample_tick in  strobe at SAMPLE_RATIO x baud
//   din         in  asynchronous serial line, idle high
//   rx_data     out last good byte
//   rx_valid    out one-clk pulse when rx_data updates
//   rx_busy     out high whenever not IDLE
//   frame_err   out one-clk pulse on a bad stop bit
//   parity_err  out one-clk pulse on parity mismatch (0 without the macro)
//
// State    | meaning
// IDLE     | line idle, waiting for a low synced sample
// START    | validating the start bit
// DATA     | shifting in data bits
// PARITY   | checking the parity bit (macro only)
// STOP     | checking the stop bit
// BREAK    | stop bit was low; wait for the line to go high
module uart_rx_oversampler
    import uart_pkg::*;
#(
    parameter int SAMPLE_RATIO = UART_SAMPLE_RATIO,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 din,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int CW = $clog2(SAMPLE_RATIO);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int M  = SAMPLE_RATIO / 2;

    logic w_din_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (din),
        .o_q   (w_din_s)
    );

    uart_state_e          r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [BW-1:0]        r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid, r_frame_err, r_parity_err;
    logic                 w_valid_nxt, w_ferr_nxt, w_perr_nxt;
    logic                 w_wrap, w_dec_pt, w_dec, w_par_ok;

    assign w_wrap   = (r_cnt == CW'(SAMPLE_RATIO - 1));
    assign w_dec_pt = (r_cnt == CW'(M + 1));
    // The third vote is the live synced sample on the decision tick.
    assign w_dec    = majority3(r_samp[0], r_samp[1], w_din_s);

`ifdef UART_RX_PARITY_EN
    logic r_par_bad, w_pbad_nxt;
    assign w_par_ok = ~r_par_bad;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD;
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_pbad_nxt  = r_par_bad;
`endif
        if (sample_tick) begin
            w_cnt_nxt = w_wrap ? '0 : r_cnt + CW'(1);
            case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                    w_pbad_nxt = 1'b0;
`endif
                    if (!w_din_s) begin
                        w_state_nxt = START;
                    end
                end
                START: begin
                    if (w_dec_pt && w_dec) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_wrap) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                    end
                end
                DATA: begin
                    if (w_dec_pt) begin
                        w_shift_nxt = {w_dec, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_wrap) begin
                        if (r_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end else begin
                            w_bit_nxt = r_bit + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_dec_pt && (w_dec != ((^r_shift) ^ PARITY_ODD))) begin
                        w_perr_nxt = 1'b1;
                        w_pbad_nxt = 1'b1;
                    end
                    if (w_wrap) begin
                        w_state_nxt = STOP;
                    end
                end
`endif
                STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is caught.
                    if (w_dec_pt) begin
                        w_cnt_nxt = '0;
                        if (w_dec) begin
                            w_state_nxt = IDLE;
                            w_valid_nxt = w_par_ok;
                        end else begin
                            w_state_nxt = BREAK;
                            w_ferr_nxt  = 1'b1;
                        end
                    end
                end
                BREAK: begin
                    w_cnt_nxt = '0;
                    if (w_din_s) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_samp       <= 2'b11;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_bit        <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_rx_valid   <= w_valid_nxt;
            r_frame_err  <= w_ferr_nxt;
            r_parity_err <= w_perr_nxt;
            if (w_valid_nxt) begin
                r_rx_data <= w_shift_nxt;
            end
            if (sample_tick && r_state != IDLE) begin
                if (r_cnt == CW'(M - 1)) r_samp[0] <= w_din_s;
                if (r_cnt == CW'(M))     r_samp[1] <= w_din_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad <= 1'b0;
        end else begin
            r_par_bad <= w_pbad_nxt;
        end
    end
`endif

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_busy    = (r_state != IDLE);
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
module tb_uart_rx_oversampler;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       din = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, parity_err;

    uart_rx_oversampler #(
        .SAMPLE_RATIO (16),
        .DATA_BITS    (8),
        .PARITY_ODD   (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .din         (din),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tph = 0;
    always @(negedge clk) begin
        tph = (tph + 1) % 4;
        sample_tick = (tph == 0);
    end

    // kind: 0 = rx_valid, 1 = frame_err, 2 = parity_err
    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         valid_cyc[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference outcome of one frame, from the frame rules alone.
    task automatic push_exp(input logic [7:0] d, input bit stop, input bit pflip);
        bit bad_par;
        bad_par = 1'b0;
`ifdef UART_RX_PARITY_EN
        bad_par = pflip;
        if (bad_par) exp_q.push_back('{2, last_good});
`else
        if (pflip) bad_par = 1'b0;
`endif
        if (stop) begin
            if (!bad_par) begin
                exp_q.push_back('{0, d});
                last_good = d;
            end
        end else begin
            exp_q.push_back('{1, last_good});
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int glitch_bit, input bit pflip);
        din = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            din = d[i];
            if (i == glitch_bit) begin
                repeat (36) @(negedge clk);
                din = ~d[i];
                repeat (4) @(negedge clk);
                din = d[i];
                repeat (BIT_CLK - 40) @(negedge clk);
            end else begin
                repeat (BIT_CLK) @(negedge clk);
            end
        end
`ifdef UART_RX_PARITY_EN
        din = (^d) ^ pflip;
        repeat (BIT_CLK) @(negedge clk);
`else
        if (pflip) din = 1'b1;
`endif
        din = stop;
        repeat (BIT_CLK) @(negedge clk);
        din = 1'b1;
    endtask

    task automatic idle_clk(input int n);
        din = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor / scoreboard
    exp_t e;
    int   kind;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid || frame_err || parity_err) begin
                kind = rx_valid ? 0 : (frame_err ? 1 : 2);
                chk("event_onehot", int'(rx_valid) + int'(frame_err) + int'(parity_err), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", kind, 99);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("event_rx_data", rx_data, e.data);
                    chk("event_rx_busy", rx_busy, (kind != 0));
                    if (kind == 0) valid_cyc.push_back(cyc);
                end
            end
            if (prev_valid) chk("rx_valid_one_clk", rx_valid, 0);
            if (prev_ferr)  chk("frame_err_one_clk", frame_err, 0);
        end
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
    end

    int busy_n;
    int nv;
    logic [7:0] d;
    bit stop_b, pflip_b;
    int gb;

    initial begin
        rst_n = 1'b0;
        din   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_busy", rx_busy, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_parity_err", parity_err, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_line_busy", rx_busy, 0);

        // 0x55 good frame
        push_exp(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, -1, 1'b0);
        chk("busy_after_stop", rx_busy, 0);
        idle_clk(BIT_CLK);

        // false start: low for 5 ticks
        busy_n = 0;
        din = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 19) din = 1'b1;
            if (rx_busy) busy_n++;
        end
        chk("false_start_busy_len", (busy_n >= 36 && busy_n <= 44), 1);
        chk("false_start_idle", rx_busy, 0);

        // bad stop, then recovery
        push_exp(8'hA3, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b0, -1, 1'b0);
        idle_clk(2 * BIT_CLK);
        chk("break_exit_idle", rx_busy, 0);
        push_exp(8'h0F, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, -1, 1'b0);
        idle_clk(BIT_CLK);

        // single-tick glitch in bit 3
        push_exp(8'h00, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 3, 1'b0);
        idle_clk(BIT_CLK);

        // randomized frames
        for (int n = 0; n < 12; n++) begin
            d       = 8'($urandom_range(0, 255));
            stop_b  = ($urandom_range(0, 4) != 0);
            pflip_b = ($urandom_range(0, 3) == 0);
            gb      = $urandom_range(0, 11);
            push_exp(d, stop_b, pflip_b);
            send_frame(d, stop_b, gb, pflip_b);
            idle_clk($urandom_range(1, 3) * BIT_CLK + $urandom_range(0, 7));
        end

        // make sure rx_data is non-zero before the mid-frame reset
        push_exp(8'h96, 1'b1, 1'b0);
        send_frame(8'h96, 1'b1, -1, 1'b0);
        idle_clk(BIT_CLK);

        // reset during bit 4
        din = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            din = i[0];
            repeat (BIT_CLK) @(negedge clk);
        end
        din = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_rx_data", rx_data, 8'h00);
        chk("midreset_rx_busy", rx_busy, 0);
        chk("midreset_rx_valid", rx_valid, 0);
        rst_n = 1'b1;
        last_good = 8'h00;
        idle_clk(2 * BIT_CLK);
        chk("after_reset_busy", rx_busy, 0);
        push_exp(8'hC8, 1'b1, 1'b0);
        send_frame(8'hC8, 1'b1, -1, 1'b0);
        idle_clk(BIT_CLK);

        // back-to-back frames, no idle gap
        nv = valid_cyc.size();
        push_exp(8'h12, 1'b1, 1'b0);
        push_exp(8'h34, 1'b1, 1'b1);
        send_frame(8'h12, 1'b1, -1, 1'b0);
        send_frame(8'h34, 1'b1, -1, 1'b1);
        idle_clk(2 * BIT_CLK);
`ifdef UART_RX_PARITY_EN
        chk("b2b_valid_count", valid_cyc.size() - nv, 1);
`else
        chk("b2b_valid_count", valid_cyc.size() - nv, 2);
        if (valid_cyc.size() - nv == 2)
            chk("b2b_spacing", valid_cyc[nv+1] - valid_cyc[nv], 10 * BIT_CLK);
`endif

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
